// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: control, redirect, instruction-memory and IF/ID signals of the fetch stage.
interface pc_fetch_unit_if;
  logic [31:0] jump_target;
  logic        jump_en;
  logic        jump_reg_en;
  logic [31:0] reg_target;
  logic        branch_en;
  logic [31:0] branch_offset;
  logic        stall;
  logic        flush;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc;
  logic [31:0] ifid_instruction;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic [15:0] squash_count;
  modport master (
    output jump_target, jump_en, jump_reg_en, reg_target, branch_en, branch_offset,
           stall, flush, imem_data,
    input  imem_addr, pc, ifid_instruction, ifid_pc_plus4, ifid_valid, squash_count
  );
  modport slave (
    input  jump_target, jump_en, jump_reg_en, reg_target, branch_en, branch_offset,
           stall, flush, imem_data,
    output imem_addr, pc, ifid_instruction, ifid_pc_plus4, ifid_valid, squash_count
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter, next-PC selection and IF/ID register with bubble insertion.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input logic         clk,
  input logic         rst,
  pc_fetch_unit_if.slave bus
);
  logic [31:0] pc, pc_plus4, next_pc, instr, ifid_pc4, jump_addr, branch_addr;
  logic [15:0] squash_count;
  logic        valid, take_jr, take_j, take_br, squash;
  // Redirects only come from a real instruction in ID; a bubble's enables are stale.
  always_comb begin
    pc_plus4    = pc + 32'd4;
    jump_addr   = (ifid_pc4 & 32'hF000_0000) | (bus.jump_target & 32'h0FFF_FFFF);
    branch_addr = ifid_pc4 + (bus.branch_offset << 2);
    take_jr     = valid & bus.jump_reg_en;
    take_j      = valid & bus.jump_en;
    take_br     = valid & bus.branch_en;
    squash      = take_jr | take_j | take_br | bus.flush;
    next_pc     = take_jr ? bus.reg_target :
                  take_j  ? jump_addr      :
                  take_br ? branch_addr    : pc_plus4;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc           <= RESET_PC;
      instr        <= NOP_WORD;
      ifid_pc4     <= 32'd0;
      valid        <= 1'b0;
      squash_count <= 16'd0;
    end else if (!bus.stall) begin
      pc           <= next_pc;
      instr        <= squash ? NOP_WORD : bus.imem_data;
      ifid_pc4     <= squash ? 32'd0 : pc_plus4;
      valid        <= !squash;
      squash_count <= (squash && squash_count != 16'hFFFF) ? squash_count + 16'd1 : squash_count;
    end
  end
  assign bus.imem_addr        = pc;
  assign bus.pc               = pc;
  assign bus.ifid_instruction = instr;
  assign bus.ifid_pc_plus4    = ifid_pc4;
  assign bus.ifid_valid       = valid;
  assign bus.squash_count     = squash_count;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: vector table, corner-case sequences and randomized run against a reference model.
module tb_pc_fetch_unit;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  pc_fetch_unit_if bus();
  pc_fetch_unit dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction
  assign bus.imem_data = mem(bus.imem_addr);
  typedef struct {
    logic s, f, jr, j, br;
    logic [31:0] rt, jt, bo;
    logic [31:0] pc, pc4;
    logic v;
    logic [15:0] cnt;
  } vec_t;
  vec_t tbl[13];
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  logic [15:0] m_cnt;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic s, f, jr, j, br, input logic [31:0] rt, jt, bo);
    bus.stall = s; bus.flush = f; bus.jump_reg_en = jr; bus.jump_en = j; bus.branch_en = br;
    bus.reg_target = rt; bus.jump_target = jt; bus.branch_offset = bo;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check_state(input string tag, input logic [31:0] pc, pc4, input logic v,
                             input logic [15:0] cnt);
    chk({tag, ".pc"}, bus.pc, pc);
    chk({tag, ".imem_addr"}, bus.imem_addr, pc);
    chk({tag, ".pc4"}, bus.ifid_pc_plus4, pc4);
    chk({tag, ".valid"}, {31'd0, bus.ifid_valid}, {31'd0, v});
    chk({tag, ".cnt"}, {16'd0, bus.squash_count}, {16'd0, cnt});
    chk({tag, ".instr"}, bus.ifid_instruction, v ? mem(pc4 - 32'd4) : 32'd0);
  endtask
  task automatic do_reset;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask
  // Reference: priority rules stated directly, one call per clock edge.
  task automatic model_step;
    logic taken;
    logic [31:0] tgt;
    if (bus.stall) return;
    taken = m_valid && (bus.jump_reg_en || bus.jump_en || bus.branch_en);
    if (bus.jump_reg_en)    tgt = bus.reg_target;
    else if (bus.jump_en)   tgt = (m_pc4 & 32'hF000_0000) | (bus.jump_target & 32'h0FFF_FFFF);
    else                    tgt = m_pc4 + bus.branch_offset * 32'd4;
    if (taken || bus.flush) begin
      m_instr = 0; m_pc4 = 0; m_valid = 0;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
    end else begin
      m_instr = mem(m_pc); m_pc4 = m_pc + 4; m_valid = 1;
    end
    m_pc = taken ? tgt : m_pc + 4;
  endtask
  initial begin
    tbl[0]  = '{0,0,0,0,0, 0, 0, 0,                       32'h4,   32'h4,   1, 0};
    tbl[1]  = '{0,0,0,0,0, 0, 0, 0,                       32'h8,   32'h8,   1, 0};
    tbl[2]  = '{0,0,0,0,0, 0, 0, 0,                       32'hC,   32'hC,   1, 0};
    tbl[3]  = '{0,0,0,0,0, 0, 0, 0,                       32'h10,  32'h10,  1, 0};
    tbl[4]  = '{0,0,0,0,1, 0, 0, 32'hFFFF_FFFE,           32'h8,   32'h0,   0, 1};
    tbl[5]  = '{0,0,0,0,1, 0, 0, 32'hFFFF_FFFE,           32'hC,   32'hC,   1, 1};
    tbl[6]  = '{0,0,1,1,0, 32'h100, 32'hF000_0040, 0,     32'h100, 32'h0,   0, 2};
    tbl[7]  = '{0,0,0,0,0, 0, 0, 0,                       32'h104, 32'h104, 1, 2};
    tbl[8]  = '{0,0,0,1,0, 0, 32'hF000_0040, 0,           32'h40,  32'h0,   0, 3};
    tbl[9]  = '{1,1,0,0,1, 0, 0, 32'h4,                   32'h40,  32'h0,   0, 3};
    tbl[10] = '{0,1,0,0,0, 0, 0, 0,                       32'h44,  32'h0,   0, 4};
    tbl[11] = '{0,0,0,0,0, 0, 0, 0,                       32'h48,  32'h48,  1, 4};
    tbl[12] = '{0,1,0,0,1, 0, 0, 32'h4,                   32'h58,  32'h0,   0, 5};
    do_reset;
    check_state("reset", 32'h0, 32'h0, 0, 0);
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].s, tbl[i].f, tbl[i].jr, tbl[i].j, tbl[i].br, tbl[i].rt, tbl[i].jt, tbl[i].bo);
      tick;
      check_state($sformatf("vec%0d", i), tbl[i].pc, tbl[i].pc4, tbl[i].v, tbl[i].cnt);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0); tick;
    drive(0, 0, 1, 0, 0, 32'h0040_000C, 0, 0); tick;
    drive(0, 0, 0, 0, 0, 0, 0, 0); tick;
    check_state("pre_jump", 32'h0040_0010, 32'h0040_0010, 1, 6);
    drive(0, 0, 0, 1, 0, 0, 32'hF3FF_FFFC, 0); tick;
    check_state("jump", 32'h03FF_FFFC, 32'h0, 0, 7);
    drive(0, 0, 0, 0, 0, 0, 0, 0); tick;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 1, 0, 0, 32'hFFFF_FFFE); tick;
      check_state($sformatf("stall%0d", i), 32'h0400_0000, 32'h0400_0000, 1, 7);
    end
    drive(0, 0, 0, 0, 1, 0, 0, 32'hFFFF_FFFE); tick;
    check_state("stall_release", 32'h03FF_FFF8, 32'h0, 0, 8);
    tick;
    check_state("branch_once", 32'h03FF_FFFC, 32'h03FF_FFFC, 1, 8);
    drive(0, 0, 0, 1, 0, 0, 32'h0000_1000, 0);
    #2 rst = 1'b1;
    #1 check_state("async_reset", 32'h0, 32'h0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    check_state("first_fetch", 32'h4, 32'h4, 1, 0);
    do_reset;
    m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0,
            $urandom_range(0, 6) == 0, $urandom_range(0, 5) == 0, $urandom, $urandom,
            $urandom_range(0, 1) ? $urandom_range(0, 64) : -$urandom_range(1, 64));
      model_step;
      tick;
      if (i % 10 == 0 || bus.pc !== m_pc || bus.ifid_instruction !== m_instr ||
          bus.ifid_pc_plus4 !== m_pc4 || bus.ifid_valid !== m_valid || bus.squash_count !== m_cnt) begin
        chk($sformatf("rnd%0d.pc", i), bus.pc, m_pc);
        chk($sformatf("rnd%0d.instr", i), bus.ifid_instruction, m_instr);
        chk($sformatf("rnd%0d.pc4", i), bus.ifid_pc_plus4, m_pc4);
        chk($sformatf("rnd%0d.valid", i), {31'd0, bus.ifid_valid}, {31'd0, m_valid});
        chk($sformatf("rnd%0d.cnt", i), {16'd0, bus.squash_count}, {16'd0, m_cnt});
      end
    end
    do_reset;
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    repeat (65540) @(posedge clk);
    #1;
    check_state("saturate", 32'h0004_0010, 32'h0, 0, 16'hFFFF);
    drive(0, 0, 0, 0, 0, 0, 0, 0); tick;
    drive(0, 0, 1, 0, 0, 32'hFFFF_FFFC, 0, 0); tick;
    check_state("to_top", 32'hFFFF_FFFC, 32'h0, 0, 16'hFFFF);
    drive(0, 0, 0, 0, 0, 0, 0, 0); tick;
    check_state("wrap", 32'h0, 32'h0, 1, 16'hFFFF);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Instruction-fetch stage that owns the program counter and the IF/ID pipeline register. It consumes the 32-bit jump word from the jump-extension stage, branch offsets, and register jump targets resolved in ID, and selects the next PC. It drives the instruction-memory address and latches the fetched instruction with its PC+4 into IF/ID. Redirects squash the wrong-path fetch with a bubble, and stalls from the hazard unit freeze the stage.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_WORD, 32'h0000_0000, instruction word inserted as a bubble.

Ports:
Clk  input  1  clock; all state updates on the rising edge.
Reset  input  1  asynchronous, active-high reset.
JumpTarget  input  32  extended jump word from the jump-extension stage (instr[25:0]<<2, upper 4 bits sign-filled).
JumpEn  input  1  ID holds j/jal; redirect to the jump target.
JumpRegEn  input  1  ID holds jr/jalr; redirect to RegTarget.
RegTarget  input  32  register value for jr.
BranchEn  input  1  ID branch resolved taken.
BranchOffset  input  32  sign-extended word offset (imm16 extended, not yet shifted).
Stall  input  1  hazard unit freeze request.
Flush  input  1  external squash of the IF/ID contents.
IMemAddr  output  32  instruction-memory address; equals PC, combinational read.
IMemData  input  32  instruction word at IMemAddr, same cycle.
PC  output  32  current PC register.
IFID_Instruction  output  32  latched instruction.
IFID_PCPlus4  output  32  latched PC+4 of that instruction.
IFID_Valid  output  1  1 = real instruction, 0 = bubble.
SquashCount  output  16  number of bubbles inserted; saturates at 16'hFFFF.

Behaviour:
- Reset (async, Reset=1): PC=RESET_PC, IFID_Instruction=NOP_WORD, IFID_PCPlus4=0, IFID_Valid=0, SquashCount=0. Reset asserted mid-operation discards any redirect or stall in progress. First fetch happens at RESET_PC on the first edge after Reset falls.
- Internal PCPlus4 = PC + 32'd4. All arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.
- Jump address = {IFID_PCPlus4[31:28], JumpTarget[27:0]}. The upper 4 bits of JumpTarget are ignored.
- Branch address = IFID_PCPlus4 + {BranchOffset[29:0], 2'b00}.
- Each rising edge is evaluated by priority, highest first:
  1. Stall=1: PC, IF/ID and SquashCount all hold. JumpEn, JumpRegEn, BranchEn and Flush are ignored; the hazard unit re-presents them.
  2. JumpRegEn=1: next PC = RegTarget.
  3. JumpEn=1: next PC = jump address.
  4. BranchEn=1: next PC = branch address.
  5. Flush=1 with no redirect: PC = PCPlus4.
  6. Otherwise: PC = PCPlus4, IF/ID = {IMemData, PCPlus4, Valid=1}.
- For a redirect (cases 2-4) or Flush (case 5): IF/ID = {NOP_WORD, 0, Valid=0} and SquashCount increments once, saturating. A redirect together with Flush counts once.
- When more than one redirect enable is asserted, the priority above decides; there is no error.
- Redirect latency: the target PC appears on IMemAddr in the cycle after the edge where the enable was sampled. Exactly one wrong-path instruction is squashed; there is no delay slot.
- A redirect enable is only honoured when IFID_Valid=1. If IFID_Valid=0, the enables are ignored and the stage advances sequentially. This prevents a stale redirect from a bubble.
- PC low two bits are not masked. A misaligned RegTarget propagates unchanged.

Test Plan:
- Reset, then 4 free-running cycles with IMemData = word at addr -> PC goes 0,4,8,12,16. IFID_PCPlus4 goes 4,8,12,16. IFID_Valid=1 from the first edge.
- IFID_PCPlus4=32'h0040_0010, JumpTarget=32'hF3FF_FFFC, JumpEn=1 -> PC=32'h03FF_FFFC next cycle. IFID_Valid=0, SquashCount=1.
- IFID_PCPlus4=32'h0000_0020, BranchOffset=32'hFFFF_FFFE, BranchEn=1 -> PC=32'h0000_0018, bubble inserted. Repeat with JumpRegEn=1 and RegTarget=32'h100 asserted at the same time -> PC=32'h100.
- Stall=1 for 3 cycles with BranchEn=1 -> PC, IF/ID and SquashCount unchanged. On Stall falling, the branch is taken once.
- Reset asserted asynchronously mid-cycle during a pending JumpEn -> outputs return to reset values immediately. The first fetch after release is RESET_PC.
- Force 65536+ flushes -> SquashCount sticks at 16'hFFFF. PC=32'hFFFF_FFFC advances to 0.
